// File: rtl/bayer_frame_sequencer.sv
// -----------------------------------------------------------------------------
// bayer_frame_sequencer
//
// Purpose: walks a Bayer frame in raster order, one pixel at a time. For each
// pixel it fetches the 5x5 neighbourhood, hands it to the grey-conversion ALU
// together with the Bayer region code and writes the grey result back to
// address y*img_w + x. Pixels are not pipelined: fetch, compute, release and
// write complete before the next fetch starts.
//
// Optional feature: define BAYER_SEQ_TIMEOUT_EN to add a COMPUTE watchdog.
// After 255 cycles without ula_done the pixel is written as 8'h00, the sticky
// err_timeout output is set and the frame continues. err_timeout clears on
// reset or on an accepted start. Without the macro, COMPUTE waits forever and
// the err_timeout port does not exist.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle frame start, accepted only when idle
//   img_w, img_h        frame dimensions, sampled on accepted start
//   bayer_phase         XOR mask for the region code, sampled on start
//   win_req/win_x/win_y window fetch request centred on (win_x, win_y)
//   win_valid/win_data  window response, pixel (r,c) at bits [40r+8c +: 8]
//   ula_matriz/ula_region/ula_start   ALU operands and start (level)
//   ula_done/ula_result ALU completion and grey value
//   wr_en/wr_addr/wr_data   output pixel write
//   busy, frame_done    status; frame_done is a one-cycle pulse
//   err_timeout         sticky watchdog flag (BAYER_SEQ_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module bayer_frame_sequencer #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [1:0]        bayer_phase,
  output logic              win_req,
  output logic [DIM_W-1:0]  win_x,
  output logic [DIM_W-1:0]  win_y,
  input  logic              win_valid,
  input  logic [199:0]      win_data,
  output logic [199:0]      ula_matriz,
  output logic [1:0]        ula_region,
  output logic              ula_start,
  input  logic              ula_done,
  input  logic [7:0]        ula_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              frame_done
`ifdef BAYER_SEQ_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    COMPUTE = 3'd2,
    RELEASE = 3'd3,
    WRITE   = 3'd4,
    FINISH  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   x_q, x_d;
  logic [DIM_W-1:0]   y_q, y_d;
  logic [DIM_W-1:0]   w_q, w_d;
  logic [DIM_W-1:0]   h_q, h_d;
  logic [1:0]         phase_q, phase_d;
  logic [199:0]       matriz_q, matriz_d;
  logic [1:0]         region_q, region_d;
  logic [7:0]         result_q, result_d;
  logic [2*DIM_W-1:0] addr_full;

`ifdef BAYER_SEQ_TIMEOUT_EN
  logic [7:0]         tmo_q, tmo_d;
  logic               err_q, err_d;
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    phase_d  = phase_q;
    matriz_d = matriz_q;
    region_d = region_q;
    result_d = result_q;
`ifdef BAYER_SEQ_TIMEOUT_EN
    tmo_d    = 8'd0;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          w_d     = img_w;
          h_d     = img_h;
          phase_d = bayer_phase;
          x_d     = '0;
          y_d     = '0;
`ifdef BAYER_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (win_valid) begin
          matriz_d = win_data;
          // Region is fixed for the whole COMPUTE visit, so compute it once here.
          region_d = {y_q[0], x_q[0]} ^ phase_q;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        if (ula_done) begin
          result_d = ula_result;
          state_d  = RELEASE;
        end
`ifdef BAYER_SEQ_TIMEOUT_EN
        // tmo_q counts completed COMPUTE cycles; 254 means this is the 255th.
        else if (tmo_q == 8'd254) begin
          result_d = 8'h00;
          err_d    = 1'b1;
          state_d  = RELEASE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      RELEASE: begin
        // One cycle with ula_start low re-arms the ALU.
        state_d = WRITE;
      end
      WRITE: begin
        if (x_q == w_q - DIM_W'(1)) begin
          x_d = '0;
          y_d = y_q + DIM_W'(1);
          if (y_q == h_q - DIM_W'(1)) begin
            state_d = FINISH;
          end else begin
            state_d = FETCH;
          end
        end else begin
          x_d     = x_q + DIM_W'(1);
          state_d = FETCH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      phase_q  <= '0;
      matriz_q <= '0;
      region_q <= '0;
      result_q <= '0;
`ifdef BAYER_SEQ_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      phase_q  <= phase_d;
      matriz_q <= matriz_d;
      region_q <= region_d;
      result_q <= result_d;
`ifdef BAYER_SEQ_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  // Full-width product, truncated to the address width below.
  assign addr_full = ({{DIM_W{1'b0}}, y_q} * {{DIM_W{1'b0}}, w_q})
                   + {{DIM_W{1'b0}}, x_q};

  // Status and handshake outputs decode directly from the state register.
  assign busy       = (state_q != IDLE);
  assign win_req    = (state_q == FETCH);
  assign ula_start  = (state_q == COMPUTE);
  assign wr_en      = (state_q == WRITE);
  assign frame_done = (state_q == FINISH);
  assign win_x      = x_q;
  assign win_y      = y_q;
  assign ula_matriz = matriz_q;
  assign ula_region = region_q;
  assign wr_addr    = (state_q == WRITE) ? ADDR_W'(addr_full) : '0;
  assign wr_data    = (state_q == WRITE) ? result_q : 8'h00;

`ifdef BAYER_SEQ_TIMEOUT_EN
  assign err_timeout = err_q;
`endif

endmodule
